// File: rtl/decoder_pipe.sv
// decoder_pipe: registered SEL_W-to-2**SEL_W decoder with valid/ready on
// both sides. Modes: one-hot, thermometer, and a multi-cycle scan that
// emits one-hot words from sel up to the top index, one per handshake.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | accepting requests; output register holds at most one word
// SCAN  | scan in progress; cnt is the index of the word now presented
module decoder_pipe #(
  parameter int SEL_W      = 3,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**SEL_W-1:0]   dec_out,
  output logic                  out_last
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};
  // XOR mask applied when loading dec_out; also the reset value.
  localparam logic [OUT_W-1:0] POL = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  cnt;
  logic [SEL_W-1:0]  cnt_nxt;
  logic              in_fire;
  logic              out_fire;

  function automatic logic [OUT_W-1:0] one_hot(input logic [SEL_W-1:0] idx);
    one_hot = ONE << idx;
  endfunction

  // Bits 0..idx set: the one-hot bit ORed with every bit below it.
  function automatic logic [OUT_W-1:0] thermo(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] m;
    m      = one_hot(idx);
    thermo = m | (m - ONE);
  endfunction

  // Accept only in IDLE when the single output slot is free or being freed.
  assign in_ready = (state == IDLE) & (~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // Never used at the top index (out_last ends the scan first), so no wrap.
  assign cnt_nxt  = cnt + {{(SEL_W-1){1'b0}}, 1'b1};

  // Request FSM with the output word, last flag and scan counter registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      dec_out   <= POL;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            out_valid <= 1'b1;
            case (mode)
              2'b01: begin
                dec_out  <= thermo(sel) ^ POL;
                out_last <= 1'b1;
              end
              2'b10: begin
                cnt      <= sel;
                dec_out  <= one_hot(sel) ^ POL;
                out_last <= &sel;
                if (!(&sel)) state <= SCAN;
              end
              default: begin
                dec_out  <= one_hot(sel) ^ POL;
                out_last <= 1'b1;
              end
            endcase
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
        end
        SCAN: begin
          if (out_fire) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              cnt      <= cnt_nxt;
              dec_out  <= one_hot(cnt_nxt) ^ POL;
              out_last <= &cnt_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_pipe.sv
module tb_decoder_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] sel;
  logic [1:0] mode;
  logic       out_ready;

  logic       in_ready,  out_valid,  out_last;
  logic [7:0] dec_out;
  logic       in_ready_al, out_valid_al, out_last_al;
  logic [7:0] dec_out_al;

  int checks = 0;
  int errors = 0;
  logic [8:0] q[$];   // {out_last, dec_out} expected, in order

  always #5 clk = ~clk;

  decoder_pipe #(.SEL_W(3), .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .dec_out(dec_out), .out_last(out_last));

  decoder_pipe #(.SEL_W(3), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_al),
    .sel(sel), .mode(mode), .out_valid(out_valid_al), .out_ready(out_ready),
    .dec_out(dec_out_al), .out_last(out_last_al));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] w, input logic last);
    q.push_back({last, w});
  endtask

  // Hold a request until accepted; returns at accept edge + 1.
  task automatic send(input logic [1:0] m, input logic [2:0] s, output int tries);
    logic acc;
    in_valid = 1'b1; mode = m; sel = s; acc = 1'b0; tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  // Monitor: every output handshake pops and compares one expected word.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", {23'd0, out_last, dec_out}, 32'h1ff);
        end else begin
          e = q.pop_front();
          chk("word", {23'd0, out_last, dec_out}, {23'd0, e});
          chk("word_active_low", {22'd0, out_valid_al, out_last_al, dec_out_al},
              {22'd0, 1'b1, e[8], ~e[7:0]});
        end
      end
    end
  end

  initial begin
    int t;
    logic [7:0] scan_exp [4];
    logic       scan_rdy [4];
    scan_exp = '{8'h20, 8'h40, 8'h40, 8'h80};
    scan_rdy = '{1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = '0; mode = '0;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_dec_out", 32'(dec_out), 32'h00);
    chk("reset_out_last", 32'(out_last), 32'd0);
    chk("reset_dec_out_al", 32'(dec_out_al), 32'hff);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // One-hot sweep, back to back
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(8'(1 << i), 1'b1);
      send(2'b00, 3'(i), t);
      chk("sweep_no_bubble", 32'(t), 32'd1);
      chk("sweep_latency", {23'd0, out_valid, dec_out}, {23'd0, 1'b1, 8'(1 << i)});
    end
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    chk("sweep_idle_valid", 32'(out_valid), 32'd0);

    // Thermometer
    push(8'h01, 1'b1); send(2'b01, 3'd0, t);
    push(8'h0f, 1'b1); send(2'b01, 3'd3, t);
    push(8'hff, 1'b1); send(2'b01, 3'd7, t);
    in_valid = 1'b0;
    drain();

    // Reserved mode behaves as one-hot
    push(8'h10, 1'b1); send(2'b11, 3'd4, t);
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;

    // Scan from 5 with a stall cycle; a pending request must not be taken
    push(8'h20, 1'b0); push(8'h40, 1'b0); push(8'h80, 1'b1);
    send(2'b10, 3'd5, t);
    mode = 2'b00; sel = 3'd1;   // in_valid stays high; mode/sel changes ignored
    for (int i = 0; i < 4; i++) begin
      out_ready = scan_rdy[i];
      @(negedge clk);
      chk("scan_in_ready_low", 32'(in_ready), 32'd0);
      chk("scan_word", {23'd0, out_valid, dec_out}, {23'd0, 1'b1, scan_exp[i]});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("scan_done_valid", 32'(out_valid), 32'd0);
    chk("scan_done_in_ready", 32'(in_ready), 32'd1);
    chk("scan_queue", 32'(q.size()), 32'd0);

    // Scan from the top index: single last word
    push(8'h80, 1'b1);
    send(2'b10, 3'd7, t);
    in_valid = 1'b0;
    chk("scan7_last", {23'd0, out_last, dec_out}, {23'd0, 1'b1, 8'h80});
    drain();
    @(posedge clk); #1;
    chk("scan7_single", 32'(out_valid), 32'd0);

    // Back-pressure with a second request waiting
    out_ready = 1'b0;
    push(8'h08, 1'b1); push(8'h07, 1'b1);
    send(2'b00, 3'd3, t);
    mode = 2'b01; sel = 3'd2;  // in_valid still high
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_hold", {23'd0, out_valid, dec_out}, {23'd0, 1'b1, 8'h08});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_high", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_same_edge_load", {23'd0, out_valid, dec_out}, {23'd0, 1'b1, 8'h07});
    drain();
    @(posedge clk); #1;

    // Async reset partway through a scan from 2
    push(8'h04, 1'b0); push(8'h08, 1'b0);
    send(2'b10, 3'd2, t);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("midscan_third_word", 32'(dec_out), 32'h10);
    #2 reset = 1'b1;
    #1;
    chk("midscan_reset_valid", 32'(out_valid), 32'd0);
    chk("midscan_reset_dec", 32'(dec_out), 32'h00);
    chk("midscan_reset_last", 32'(out_last), 32'd0);
    chk("midscan_reset_dec_al", 32'(dec_out_al), 32'hff);
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_reset_no_stray", 32'(out_valid), 32'd0);
    end
    push(8'h02, 1'b1);
    send(2'b00, 3'd1, t);
    in_valid = 1'b0;
    drain();
    @(posedge clk); #1;
    chk("final_idle", {30'd0, out_valid, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Parametrised, registered successor to the team's fixed 3-to-8 gate-level decoder.
- Decodes an SEL_W-bit index into a 2**SEL_W-bit output vector in one of three modes: one-hot, thermometer, or multi-cycle scan.
- Valid/ready on both sides.
- Drives register-file and bank write-enables in the datapath, where output timing must be registered and back-pressurable.

Parameters:
- SEL_W, 3, index width; output width OUT_W = 2**SEL_W is derived internally, not overridable.
- ACTIVE_LOW, 0, when 1 the dec_out bits are inverted at the output register; dec_out reset value follows this parameter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid and in_ready are both high on a clk edge.
- sel  input  SEL_W  index.
- mode  input  2  00 one-hot, 01 thermometer, 10 scan, 11 reserved (treated as one-hot).
- out_valid  output  1  dec_out holds a valid word.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both high.
- dec_out  output  2**SEL_W  decoded word.
- out_last  output  1  high on the final word of a request; always 1 for one-hot and thermometer.

Behaviour:
- Reset (async, asserted):
  - out_valid=0, out_last=0.
  - dec_out = all 0 (ACTIVE_LOW=0) or all 1 (ACTIVE_LOW=1).
  - FSM to IDLE; scan counter = 0.
- Output register: single entry. An entry is freed by out_valid&out_ready.
- Latency: accept edge -> out_valid high after that same edge (1 cycle). No combinational path from in_valid/sel to outputs.
- FSM IDLE:
  - in_ready = !out_valid | out_ready.
  - One-hot accept: dec_out bit sel = 1, all others 0. out_last=1. Stay IDLE.
  - Thermometer accept: bits 0..sel = 1, rest 0. sel=0 gives 0...01; sel=OUT_W-1 gives all ones. out_last=1. Stay IDLE.
  - Scan accept: load cnt=sel, emit one-hot(sel), out_last = (sel==OUT_W-1), go to SCAN unless out_last.
- FSM SCAN:
  - in_ready=0.
  - On each output handshake: cnt=cnt+1, emit one-hot(cnt+1), out_last=(cnt+1==OUT_W-1).
  - On the handshake of the word with out_last=1: return to IDLE.
  - No wrap-around: scan ends at index OUT_W-1.
- Back-pressure: while out_valid & !out_ready, dec_out, out_last and cnt hold stable.
- Simultaneous events: in IDLE, an output handshake and an input accept on the same edge load the new word with no bubble; out_valid stays 1.
- mode and sel are sampled only on accept. Changes at other times are ignored.
- ACTIVE_LOW inversion applies to dec_out only, never to out_valid or out_last.
- Reset mid-scan: async clear per the reset list above. The partial scan is abandoned and no further words are emitted.
- Arithmetic: cnt is SEL_W bits wide. The increment is never applied at OUT_W-1, so overflow cannot occur.

Test Plan:
- Reset, SEL_W=3: assert reset asynchronously between edges -> out_valid=0 and dec_out=8'h00 immediately. With ACTIVE_LOW=1 -> dec_out=8'hFF.
- One-hot sweep, out_ready=1: sel=0..7, one per cycle -> dec_out = 01,02,04,...,80, out_last=1 each, in_ready=1 throughout, one cycle latency, no bubbles.
- Thermometer: sel=0, 3, 7 -> dec_out = 8'h01, 8'h0F, 8'hFF.
- Scan with stall, mode=10, sel=5, out_ready toggling 1,0,1,1:
  - Words 8'h20, 8'h40, 8'h80; out_last only on 8'h80.
  - Word held stable during the stall.
  - in_ready=0 until the last handshake.
  - Scan from sel=7 yields a single word 8'h80 with out_last=1.
- Back-pressure: out_ready=0 with a second in_valid pending -> in_ready=0, first word held. Raise out_ready -> second word loaded on the same edge.
- Reset during scan started at sel=2, after 2 words -> outputs cleared. After release, a one-hot sel=1 request yields 8'h02 with no stray scan words.
